// File: rtl/page_server_pkg.sv
// page_server shared definitions: page geometry, page/index types and the
// sequencer state enum.
package page_server_pkg;

  localparam int WIDTH = 25;
  localparam int PAGES = 64;
  localparam int IDX_W = 6;

  typedef logic [WIDTH-1:0] page_t;
  typedef logic [IDX_W-1:0] idx_t;

  typedef enum logic [1:0] {
    LOAD,
    KICK,
    RUN,
    DRAIN
  } state_t;

endpackage

// File: rtl/page_server_if.sv
// page_server bus: upstream page writes, stage page interface, downstream
// result stream and status. master = environment side, slave = page_server.
interface page_server_if;
  import page_server_pkg::*;

  logic  wr_valid;
  page_t wr_data;
  logic  wr_ready;

  logic  stage_start;
  idx_t  stage_index;
  page_t stage_in;
  page_t stage_out;
  logic  stage_ready;
  logic  stage_done;

  logic  rd_valid;
  page_t rd_data;
  logic  rd_ready;

  logic  busy;
  logic  err;

  modport master (
    output wr_valid, wr_data, stage_index, stage_out, stage_ready, stage_done, rd_ready,
    input  wr_ready, stage_start, stage_in, rd_valid, rd_data, busy, err
  );

  modport slave (
    input  wr_valid, wr_data, stage_index, stage_out, stage_ready, stage_done, rd_ready,
    output wr_ready, stage_start, stage_in, rd_valid, rd_data, busy, err
  );

endinterface

// File: rtl/page_server_bank.sv
// page_bank: PAGES x WIDTH storage with one synchronous write port, one
// combinational read port and one read port whose address is registered
// (data follows the registered address with no extra cycle of latency).
module page_bank
  import page_server_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  we,
  input  idx_t  wa,
  input  page_t wd,
  input  idx_t  ca,
  output page_t cd,
  input  idx_t  ra_d,
  output page_t rq
);

  page_t mem [PAGES];
  idx_t  ra_q;

  // write port; contents are intentionally not reset
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
  end

  // registered read address
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ra_q <= '0;
    else       ra_q <= ra_d;
  end

  assign cd = mem[ca];
  assign rq = mem[ra_q];

endmodule

// File: rtl/page_server.sv
// page_server: loads a 64-page state, kicks the column-parity stage, serves
// its page reads, captures its results and streams them downstream.
// Optional build macro: STAGE_TIMEOUT_EN enables the RUN watchdog and err.
//
// state | meaning
// LOAD  | accepting upstream pages into src_bank
// KICK  | full state held, waiting for stage_ready to pulse stage_start
// RUN   | stage working; every cycle its result is captured into res_bank
// DRAIN | streaming res_bank pages 0..63 downstream
module page_server
  import page_server_pkg::*;
#(
  parameter int TIMEOUT = 1023
) (
  input logic          clk,
  input logic          reset,
  page_server_if.slave bus
);

  state_t state, state_nxt;
  idx_t   wr_ptr, rd_ptr, rd_ptr_nxt;
  logic   wr_fire, rd_fire, wd_tc;
  logic   wr_ready, busy, stage_start, rd_valid;
  page_t  src_unused_q, res_unused_c;
  logic   unused_bits;

  assign wr_fire = (state == LOAD)  && bus.wr_valid;
  assign rd_fire = (state == DRAIN) && bus.rd_ready;

  page_bank src_bank (
    .clk(clk), .reset(reset),
    .we(wr_fire), .wa(wr_ptr), .wd(bus.wr_data),
    .ca(bus.stage_index), .cd(bus.stage_in),
    .ra_d('0), .rq(src_unused_q)
  );

  page_bank res_bank (
    .clk(clk), .reset(reset),
    .we(state == RUN), .wa(bus.stage_index), .wd(bus.stage_out),
    .ca('0), .cd(res_unused_c),
    .ra_d(rd_ptr_nxt), .rq(bus.rd_data)
  );

  assign unused_bits = ^{src_unused_q, res_unused_c};

`ifdef STAGE_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_cnt;
  logic            err_q;

  // watchdog: preload on the way into RUN, count down while in RUN, sticky err
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state == KICK)                      wd_cnt <= WD_W'(TIMEOUT - 1);
      else if (state == RUN && wd_cnt != '0)  wd_cnt <= wd_cnt - 1'b1;
      if (wd_tc) err_q <= 1'b1;
    end
  end

  assign wd_tc   = (state == RUN) && !bus.stage_done && (wd_cnt == '0);
  assign bus.err = err_q | wd_tc;
`else
  localparam int unused_timeout = TIMEOUT;
  assign wd_tc   = 1'b0;
  assign bus.err = 1'b0;
`endif

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= LOAD;
    else       state <= state_nxt;
  end

  // next-state decode; stage_done takes priority over a same-cycle timeout
  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:  if (wr_fire && wr_ptr == idx_t'(PAGES - 1)) state_nxt = KICK;
      KICK:  if (bus.stage_ready)                         state_nxt = RUN;
      RUN:   if (bus.stage_done)                          state_nxt = DRAIN;
             else if (wd_tc)                              state_nxt = LOAD;
      DRAIN: if (rd_fire && rd_ptr == idx_t'(PAGES - 1))  state_nxt = LOAD;
      default:                                            state_nxt = LOAD;
    endcase
  end

  // Moore/Mealy output decode
  always_comb begin
    wr_ready    = 1'b0;
    busy        = 1'b1;
    stage_start = 1'b0;
    rd_valid    = 1'b0;
    case (state)
      LOAD:  begin wr_ready = 1'b1; busy = 1'b0; end
      KICK:  stage_start = bus.stage_ready;
      DRAIN: rd_valid = 1'b1;
      default: ;
    endcase
  end

  assign bus.wr_ready    = wr_ready;
  assign bus.busy        = busy;
  assign bus.stage_start = stage_start;
  assign bus.rd_valid    = rd_valid;

  // next read pointer also feeds the bank's registered read address
  always_comb begin
    rd_ptr_nxt = rd_ptr;
    if (state == RUN && bus.stage_done) rd_ptr_nxt = '0;
    else if (rd_fire)                   rd_ptr_nxt = rd_ptr + 1'b1;
  end

  // page pointers; both wrap modulo PAGES by width
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_fire)    wr_ptr <= wr_ptr + 1'b1;
      else if (wd_tc) wr_ptr <= '0;
      rd_ptr <= rd_ptr_nxt;
    end
  end

endmodule

// File: tb/tb_page_server.sv
// Self-checking bench for page_server: random frames against an array model
// of the source and result page memories.
module tb_page_server;
  import page_server_pkg::*;

  localparam page_t PAT = 25'h1555555;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  page_server_if bus ();

`ifdef STAGE_TIMEOUT_EN
  page_server #(.TIMEOUT(20)) dut (.clk(clk), .reset(reset), .bus(bus));
`else
  page_server dut (.clk(clk), .reset(reset), .bus(bus));
`endif

  int    n_tests = 0;
  int    n_fail  = 0;
  page_t src_m [PAGES];
  page_t res_m [PAGES];
  logic  err_exp = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_frame(input bit patterned);
    page_t d;
    int k;
    k = 0;
    while (k < PAGES) begin
      bus.wr_valid = ($urandom_range(0, 3) != 0);
      d = patterned ? (page_t'(k) ^ PAT) : page_t'($urandom);
      bus.wr_data = d;
      #1;
      check("load_wr_ready", 32'(bus.wr_ready), 32'd1);
      check("load_busy", 32'(bus.busy), 32'd0);
      if (bus.wr_valid) begin
        src_m[k] = d;
        k++;
      end
      tick();
    end
    bus.wr_valid = 1'b0;
  endtask

  task automatic kick(input int stall);
    for (int i = 0; i < stall; i++) begin
      bus.stage_ready = 1'b0;
      bus.stage_done  = 1'($urandom_range(0, 1));
      bus.wr_valid    = 1'b1;
      bus.wr_data     = page_t'($urandom);
      #1;
      check("kick_hold_start", 32'(bus.stage_start), 32'd0);
      check("kick_wr_ready", 32'(bus.wr_ready), 32'd0);
      check("kick_busy", 32'(bus.busy), 32'd1);
      tick();
    end
    bus.wr_valid    = 1'b0;
    bus.stage_ready = 1'b1;
    bus.stage_done  = 1'b1;
    #1;
    check("kick_start", 32'(bus.stage_start), 32'd1);
    tick();
    bus.stage_done = 1'b0;
    #1;
    check("start_one_cycle", 32'(bus.stage_start), 32'd0);
  endtask

  task automatic run_stage(input int extra);
    idx_t  idx;
    page_t val;
    for (int i = 0; i < PAGES + extra; i++) begin
      idx = (i < PAGES) ? idx_t'(i) : idx_t'($urandom);
      val = (i < PAGES) ? page_t'(src_m[idx] + 1'b1) : page_t'($urandom);
      bus.stage_index = idx;
      bus.stage_out   = val;
      bus.stage_done  = (i == PAGES + extra - 1);
      #1;
      check("stage_in", 32'(bus.stage_in), 32'(src_m[idx]));
      check("run_rd_valid", 32'(bus.rd_valid), 32'd0);
      res_m[idx] = val;
      tick();
    end
    bus.stage_done = 1'b0;
  endtask

  task automatic drain(input bit rand_ready, input int reset_at);
    int k;
    k = 0;
    while (k < PAGES) begin
      bus.rd_ready    = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.stage_done  = 1'($urandom_range(0, 1));
      bus.stage_index = idx_t'($urandom);
      bus.stage_out   = page_t'($urandom);
      #1;
      if (k == reset_at) begin
        reset = 1'b1;
        #1;
        check("abort_rd_valid", 32'(bus.rd_valid), 32'd0);
        check("abort_wr_ready", 32'(bus.wr_ready), 32'd1);
        check("abort_busy", 32'(bus.busy), 32'd0);
        #2;
        reset          = 1'b0;
        bus.rd_ready   = 1'b0;
        bus.stage_done = 1'b0;
        tick();
        return;
      end
      check("drain_rd_valid", 32'(bus.rd_valid), 32'd1);
      check("drain_rd_data", 32'(bus.rd_data), 32'(res_m[k]));
      check("drain_stage_in", 32'(bus.stage_in), 32'(src_m[bus.stage_index]));
      if (bus.rd_ready) k++;
      tick();
    end
    bus.rd_ready   = 1'b0;
    bus.stage_done = 1'b0;
    #1;
    check("post_rd_valid", 32'(bus.rd_valid), 32'd0);
    check("post_wr_ready", 32'(bus.wr_ready), 32'd1);
    check("post_busy", 32'(bus.busy), 32'd0);
    check("post_err", 32'(bus.err), 32'(err_exp));
  endtask

  initial begin
    bus.wr_valid    = 1'b0;
    bus.wr_data     = '0;
    bus.stage_index = '0;
    bus.stage_out   = '0;
    bus.stage_ready = 1'b1;
    bus.stage_done  = 1'b0;
    bus.rd_ready    = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("rst_wr_ready", 32'(bus.wr_ready), 32'd1);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    check("rst_stage_start", 32'(bus.stage_start), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    reset = 1'b0;
    tick();

    // patterned frame, always-ready stage and sink
    load_frame(1'b1);
    kick(0);
    run_stage(0);
    drain(1'b0, -1);

    // random frame with kick stall, overwrites and downstream back-pressure
    load_frame(1'b0);
    kick(3);
    run_stage(10);
    drain(1'b1, -1);

    // reset during DRAIN at page 30, then a fresh frame
    load_frame(1'b0);
    kick(1);
    run_stage(5);
    drain(1'b1, 30);

    for (int f = 0; f < 4; f++) begin
      load_frame(1'b0);
      kick($urandom_range(0, 4));
      run_stage($urandom_range(0, 20));
      drain(1'b1, -1);
    end

`ifdef STAGE_TIMEOUT_EN
    load_frame(1'b0);
    kick(0);
    for (int c = 1; c <= 20; c++) begin
      bus.stage_index = idx_t'($urandom);
      bus.stage_out   = page_t'($urandom);
      check("wd_err", 32'(bus.err), (c == 20) ? 32'd1 : 32'd0);
      check("wd_wr_ready", 32'(bus.wr_ready), 32'd0);
      check("wd_rd_valid", 32'(bus.rd_valid), 32'd0);
      tick();
    end
    err_exp = 1'b1;
    check("wd_err_sticky", 32'(bus.err), 32'd1);
    check("wd_back_to_load", 32'(bus.wr_ready), 32'd1);
    check("wd_no_rd_valid", 32'(bus.rd_valid), 32'd0);
    load_frame(1'b0);
    kick(0);
    run_stage(3);
    drain(1'b1, -1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/page_server.md
Name: page_server

Overview:
- Page-memory responder/sequencer on the far end of the column-parity stage's page interface.
- Accepts a 64-page, 25-bit-per-page Keccak state serially from upstream and issues a one-cycle start to the stage.
- Serves the stage's page reads combinationally by page_index and captures its per-page results.
- Streams the 64 result pages downstream with valid/ready.

Parameters:
- WIDTH, 25, bits per page (one 5x5 slice).
- PAGES, 64, pages per state.
- IDX_W, 6, page index width; must equal clog2(PAGES).
- TIMEOUT, 1023, watchdog limit in cycles (used only with STAGE_TIMEOUT_EN).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- wr_valid  in  1  upstream page valid.
- wr_data  in  WIDTH  upstream page, page 0 first.
- wr_ready  out  1  high in LOAD state.
- stage_start  out  1  one-cycle start pulse to the stage.
- stage_index  in  IDX_W  page index requested by the stage.
- stage_in  out  WIDTH  src_bank[stage_index], combinational.
- stage_out  in  WIDTH  stage result for page stage_index.
- stage_ready  in  1  stage idle indication.
- stage_done  in  1  stage completion pulse.
- rd_valid  out  1  result page valid.
- rd_data  out  WIDTH  res_bank[rd_ptr].
- rd_ready  in  1  downstream accept.
- busy  out  1  high in any state other than LOAD.
- err  out  1  sticky watchdog error; constant 0 without STAGE_TIMEOUT_EN.

Behaviour:
- States: LOAD, KICK, RUN, DRAIN. Reset state is LOAD.
- Reset values: wr_ptr=0, rd_ptr=0, stage_start=0, rd_valid=0, busy=0, err=0, wr_ready=1 (LOAD decode). Bank contents are not reset.
- LOAD:
  - On wr_valid&&wr_ready: src_bank[wr_ptr] <= wr_data, wr_ptr++.
  - Write with wr_ptr==PAGES-1: wr_ptr wraps to 0, next state KICK.
  - Writes outside LOAD are ignored (wr_ready=0).
- KICK:
  - Wait for stage_ready=1.
  - Then stage_start=1 for exactly one cycle and go to RUN.
  - If stage_ready=0, hold in KICK with stage_start=0.
- RUN:
  - stage_in=src_bank[stage_index], zero-latency combinational read. stage_in tracks stage_index in every state.
  - Every cycle: res_bank[stage_index] <= stage_out; last write for a given index wins.
  - On stage_done=1: perform the capture that cycle, then go to DRAIN with rd_ptr=0.
- DRAIN:
  - rd_valid=1, rd_data=res_bank[rd_ptr], registered read address, no bubble between pages.
  - On rd_valid&&rd_ready: rd_ptr++.
  - Accept with rd_ptr==PAGES-1: rd_ptr wraps to 0, rd_valid drops next cycle, next state LOAD.
  - rd_data must stay stable while rd_valid&&!rd_ready.
- Boundary rules:
  - stage_done outside RUN is ignored.
  - stage_done in the same cycle as stage_start (KICK) is ignored.
  - Back-to-back frames: wr_ready rises the cycle after the final DRAIN accept.
  - Asynchronous reset mid-frame aborts immediately to LOAD. Partial data is discarded and no rd_valid is emitted.
  - Index arithmetic is modulo PAGES. No overflow flag is generated.
- Latency:
  - LOAD-to-start: 1 cycle after the 64th write when stage_ready=1.
  - stage_done to first rd_valid: 1 cycle.

Optional Feature:
- Macro: STAGE_TIMEOUT_EN.
- Defined:
  - A watchdog counter clears on entry to RUN and counts every cycle in RUN.
  - Reaching TIMEOUT without stage_done sets err=1 (sticky until reset) and forces LOAD with wr_ptr=0.
  - No rd_valid is issued for that frame.
- Undefined: no counter; err tied to 0; RUN waits indefinitely.

Decomposition:
- Shared package holds: WIDTH, PAGES, IDX_W constants; the state enum (LOAD, KICK, RUN, DRAIN); the page typedef (WIDTH-bit vector).
- One natural sub-module, page_bank: PAGES x WIDTH memory with a synchronous write port, a combinational read port and a registered read port. Instantiate it twice, as src_bank and res_bank.
- FSM and pointers stay in page_server.

Test Plan:
- Reset → wr_ready=1, busy=0, rd_valid=0, stage_start=0, err=0.
- Load pages 0..63 with wr_data=index ^ 25'h1555555, stage_ready=1 → stage_start pulses once, 1 cycle after the 64th write. Driving stage_index=5 gives stage_in=25'h1555550.
- Stage model echoes stage_out=stage_in+1 across indices 0..63, then pulses stage_done → 64 rd_valid beats with rd_ready=1, rd_data=(k ^ 25'h1555555)+1 in order k=0..63, then wr_ready=1.
- Randomly toggle rd_ready 50% during DRAIN → no page lost or duplicated; rd_data stable while stalled.
- Assert reset at page 30 of DRAIN → rd_valid=0 and state LOAD in the same cycle; a fresh frame completes correctly afterwards.
- STAGE_TIMEOUT_EN defined with TIMEOUT=20 and stage_done never asserted → err=1 at RUN cycle 20, wr_ready=1 next cycle, no rd_valid issued.
